// File: rtl/tc_psum_sched.sv
// tc_psum_sched
// Sequencing controller for the tensor-core partial-sum line buffer.
// A fill phase forwards scattered element writes from the PE tiles into the
// buffer as one-cycle strobes. After the beat marked wr_last, a short settle
// guard runs, then the buffer is drained row by row to a downstream consumer.
//
// Handshakes: every valid/ready pair transfers exactly on a cycle where both
// are high at the rising clock edge. A producer holds valid and its payload
// stable until that cycle. Ready never depends combinationally on the
// matching valid.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   wr_valid/wr_ready upstream element stream (wr_row, wr_col, wr_data, wr_last)
//   buf_row, buf_col  buffer address (write address, or read row in REQ/WAIT)
//   buf_in            buffer write data
//   buf_input_en      buffer write strobe, one cycle per forwarded element
//   buf_out_en        buffer row-read request, one cycle per row
//   buf_out_valid     buffer row-read response, qualifies buf_out
//   rd_valid/rd_ready downstream row stream (rd_data, rd_row, rd_last)
//   done              one-cycle pulse after the final row handshake
//   err_oob           sticky: an out-of-range write was dropped
//   dbg_state         current FSM state encoding
module tc_psum_sched #(
  parameter int M       = 16,
  parameter int N       = 16,
  parameter int DW_DATA = 8,
  parameter int DW_POS  = 4,
  parameter int SETTLE  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DW_POS-1:0]    wr_row,
  input  logic [DW_POS-1:0]    wr_col,
  input  logic [DW_DATA-1:0]   wr_data,
  input  logic                 wr_last,
  output logic [DW_POS-1:0]    buf_row,
  output logic [DW_POS-1:0]    buf_col,
  output logic [DW_DATA-1:0]   buf_in,
  output logic                 buf_input_en,
  output logic                 buf_out_en,
  input  logic                 buf_out_valid,
  input  logic [N*DW_DATA-1:0] buf_out,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [N*DW_DATA-1:0] rd_data,
  output logic [DW_POS-1:0]    rd_row,
  output logic                 rd_last,
  output logic                 done,
  output logic                 err_oob,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_SETTLE  = 3'd2,
    S_REQ     = 3'd3,
    S_WAIT    = 3'd4,
    S_PRESENT = 3'd5
  } state_t;

  // One extra bit so that M or N equal to 2^DW_POS still compare correctly.
  localparam logic [DW_POS:0]   M_LIM       = (DW_POS + 1)'(M);
  localparam logic [DW_POS:0]   N_LIM       = (DW_POS + 1)'(N);
  localparam logic [DW_POS-1:0] ROW_LAST    = DW_POS'(M - 1);
  localparam logic [3:0]        SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t              state;
  state_t              state_next;
  logic [3:0]          settle_cnt;
  logic [DW_POS-1:0]   row_cnt;
  logic [DW_POS-1:0]   wr_row_q;
  logic                accept;
  logic                in_range;

  assign accept   = wr_valid && wr_ready;
  assign in_range = ({1'b0, wr_row} < M_LIM) && ({1'b0, wr_col} < N_LIM);

  // The address bus is shared: the drain phase owns it in REQ/WAIT,
  // otherwise it shows the last forwarded write address.
  assign buf_row   = (state == S_REQ || state == S_WAIT) ? row_cnt : wr_row_q;
  assign rd_row    = row_cnt;
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    buf_out_en = 1'b0;
    rd_valid   = 1'b0;
    rd_last    = 1'b0;
    case (state)
      S_IDLE, S_FILL: begin
        wr_ready = !rst;
        if (wr_valid && !rst) begin
          // A dropped out-of-range beat still ends the tile if it carries wr_last.
          if (wr_last) state_next = (SETTLE == 0) ? S_REQ : S_SETTLE;
          else         state_next = S_FILL;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_next = S_REQ;
      end
      S_REQ: begin
        buf_out_en = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (buf_out_valid) state_next = S_PRESENT;
      end
      S_PRESENT: begin
        rd_valid = 1'b1;
        rd_last  = (row_cnt == ROW_LAST);
        if (rd_ready) state_next = rd_last ? S_IDLE : S_REQ;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      settle_cnt   <= 4'd0;
      row_cnt      <= '0;
      wr_row_q     <= '0;
      buf_col      <= '0;
      buf_in       <= '0;
      buf_input_en <= 1'b0;
      rd_data      <= '0;
      done         <= 1'b0;
      err_oob      <= 1'b0;
    end else begin
      state        <= state_next;
      buf_input_en <= accept && in_range;
      done         <= (state == S_PRESENT) && rd_ready && rd_last;

      if (accept && in_range) begin
        wr_row_q <= wr_row;
        buf_col  <= wr_col;
        buf_in   <= wr_data;
      end
      if (accept && !in_range) err_oob <= 1'b1;

      if (state == S_SETTLE) settle_cnt <= settle_cnt + 4'd1;
      else                   settle_cnt <= 4'd0;

      // Responses outside WAIT are stray and must not disturb rd_data.
      if (state == S_WAIT && buf_out_valid) rd_data <= buf_out;

      if (state == S_PRESENT && rd_ready) begin
        if (rd_last) row_cnt <= '0;
        else         row_cnt <= row_cnt + 1'b1;
      end
    end
  end

endmodule
